// File: rtl/mem_sl_pkg.sv
// mem_sl_pkg: shared definitions for the load/store memory stage.
//   - bus widths
//   - load/store opcodes (MIPS encoding)
//   - FSM state encoding
//   - byte-lane select constants
//   - opcode classification helpers
package mem_sl_pkg;

  localparam int DATA_BUS     = 32;
  localparam int ADDR_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int INST_OP_BUS  = 6;
  localparam int BYTE_SEL_BUS = 4;

  localparam logic [INST_OP_BUS-1:0] OP_LB  = 6'h20;
  localparam logic [INST_OP_BUS-1:0] OP_LH  = 6'h21;
  localparam logic [INST_OP_BUS-1:0] OP_LWL = 6'h22;
  localparam logic [INST_OP_BUS-1:0] OP_LW  = 6'h23;
  localparam logic [INST_OP_BUS-1:0] OP_LBU = 6'h24;
  localparam logic [INST_OP_BUS-1:0] OP_LHU = 6'h25;
  localparam logic [INST_OP_BUS-1:0] OP_LWR = 6'h26;
  localparam logic [INST_OP_BUS-1:0] OP_SB  = 6'h28;
  localparam logic [INST_OP_BUS-1:0] OP_SH  = 6'h29;
  localparam logic [INST_OP_BUS-1:0] OP_SWL = 6'h2A;
  localparam logic [INST_OP_BUS-1:0] OP_SW  = 6'h2B;
  localparam logic [INST_OP_BUS-1:0] OP_SWR = 6'h2E;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  localparam logic [BYTE_SEL_BUS-1:0] SEL_NONE = 4'b0000;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_B0   = 4'b0001;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_B1   = 4'b0010;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_B2   = 4'b0100;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_B3   = 4'b1000;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_H0   = 4'b0011;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_H1   = 4'b1100;
  localparam logic [BYTE_SEL_BUS-1:0] SEL_W    = 4'b1111;

  function automatic logic is_store_op(input logic [INST_OP_BUS-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) ||
           (op == OP_SW) || (op == OP_SWR);
  endfunction

  function automatic logic is_load_op(input logic [INST_OP_BUS-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
  endfunction

  function automatic logic is_mem_op(input logic [INST_OP_BUS-1:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  function automatic logic [BYTE_SEL_BUS-1:0] byte_sel(input logic [1:0] off);
    case (off)
      2'd0:    return SEL_B0;
      2'd1:    return SEL_B1;
      2'd2:    return SEL_B2;
      default: return SEL_B3;
    endcase
  endfunction

endpackage

// File: rtl/mem_sl_align.sv
// mem_align: purely combinational byte-lane steering for loads and stores.
// Ports:
//   op         in   opcode
//   offset     in   address bits [1:0]
//   rt         in   store data / LWL-LWR merge source
//   read_word  in   word returned by the RAM
//   ram_sel    out  byte-lane enables (bit i = byte i, little-endian)
//   write_data out  lane-aligned store data
//   load_data  out  extended or merged load result
//   misalign   out  halfword/word access not naturally aligned
module mem_align
  import mem_sl_pkg::*;
(
  input  logic [INST_OP_BUS-1:0]  op,
  input  logic [1:0]              offset,
  input  logic [DATA_BUS-1:0]     rt,
  input  logic [DATA_BUS-1:0]     read_word,
  output logic [BYTE_SEL_BUS-1:0] ram_sel,
  output logic [DATA_BUS-1:0]     write_data,
  output logic [DATA_BUS-1:0]     load_data,
  output logic                    misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    ram_sel    = SEL_NONE;
    write_data = '0;
    load_data  = '0;
    misalign   = 1'b0;

    case (offset)
      2'd0:    byte_v = read_word[7:0];
      2'd1:    byte_v = read_word[15:8];
      2'd2:    byte_v = read_word[23:16];
      default: byte_v = read_word[31:24];
    endcase
    half_v = offset[1] ? read_word[31:16] : read_word[15:0];

    case (op)
      OP_LB: begin
        ram_sel   = byte_sel(offset);
        load_data = {{24{byte_v[7]}}, byte_v};
      end
      OP_LBU: begin
        ram_sel   = byte_sel(offset);
        load_data = {24'b0, byte_v};
      end
      OP_LH: begin
        ram_sel   = offset[1] ? SEL_H1 : SEL_H0;
        load_data = {{16{half_v[15]}}, half_v};
        misalign  = offset[0];
      end
      OP_LHU: begin
        ram_sel   = offset[1] ? SEL_H1 : SEL_H0;
        load_data = {16'b0, half_v};
        misalign  = offset[0];
      end
      OP_LW: begin
        ram_sel   = SEL_W;
        load_data = read_word;
        misalign  = (offset != 2'd0);
      end
      // LWL fills the upper bytes of rt from the low end of the word.
      OP_LWL: begin
        ram_sel = SEL_W;
        case (offset)
          2'd0:    load_data = {read_word[7:0],  rt[23:0]};
          2'd1:    load_data = {read_word[15:0], rt[15:0]};
          2'd2:    load_data = {read_word[23:0], rt[7:0]};
          default: load_data = read_word;
        endcase
      end
      // LWR fills the lower bytes of rt from the high end of the word.
      OP_LWR: begin
        ram_sel = SEL_W;
        case (offset)
          2'd0:    load_data = read_word;
          2'd1:    load_data = {rt[31:24], read_word[31:8]};
          2'd2:    load_data = {rt[31:16], read_word[31:16]};
          default: load_data = {rt[31:8],  read_word[31:24]};
        endcase
      end
      OP_SB: begin
        ram_sel    = byte_sel(offset);
        write_data = {4{rt[7:0]}};
      end
      OP_SH: begin
        ram_sel    = offset[1] ? SEL_H1 : SEL_H0;
        write_data = {2{rt[15:0]}};
        misalign   = offset[0];
      end
      OP_SW: begin
        ram_sel    = SEL_W;
        write_data = rt;
        misalign   = (offset != 2'd0);
      end
      OP_SWL: begin
        case (offset)
          2'd0:    begin ram_sel = 4'b0001; write_data = {24'b0, rt[31:24]}; end
          2'd1:    begin ram_sel = 4'b0011; write_data = {16'b0, rt[31:16]}; end
          2'd2:    begin ram_sel = 4'b0111; write_data = {8'b0,  rt[31:8]};  end
          default: begin ram_sel = 4'b1111; write_data = rt;                 end
        endcase
      end
      OP_SWR: begin
        case (offset)
          2'd0:    begin ram_sel = 4'b1111; write_data = rt;                 end
          2'd1:    begin ram_sel = 4'b1110; write_data = {rt[23:0], 8'b0};  end
          2'd2:    begin ram_sel = 4'b1100; write_data = {rt[15:0], 16'b0}; end
          default: begin ram_sel = 4'b1000; write_data = {rt[7:0],  24'b0}; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_sl.sv
// mem_sl: load/store memory-access stage.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_valid, flush          instruction present from EX; pipeline flush
//   mem_op, mem_addr, rt_data, in_wreg_*   decoded instruction from EX
//   ram_*                    data-RAM bus (registered), ram_read_data/ram_ready back
//   stall_req                hold IF/ID/EX while an access is outstanding
//   out_valid, write_reg_*   WB result
//   addr_err_load/store, bad_vaddr   misalignment exception report
//   state_dbg                current FSM state (MEM_IDLE / MEM_ACCESS)
//
// Handshake: EX holds its inputs while stall_req=1; an instruction is
// accepted on a rising edge where the stage is in IDLE with in_valid=1.
// The RAM holds ram_* stable until it answers with ram_ready=1 for one
// cycle, with ram_read_data valid in that same cycle.
module mem_sl
  import mem_sl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    flush,
  input  logic [INST_OP_BUS-1:0]  mem_op,
  input  logic [ADDR_BUS-1:0]     mem_addr,
  input  logic [DATA_BUS-1:0]     rt_data,
  input  logic                    in_wreg_en,
  input  logic [REG_ADDR_BUS-1:0] in_wreg_addr,
  input  logic [DATA_BUS-1:0]     in_wreg_data,
  output logic                    ram_en,
  output logic                    ram_write_en,
  output logic [BYTE_SEL_BUS-1:0] ram_sel,
  output logic [ADDR_BUS-1:0]     ram_addr,
  output logic [DATA_BUS-1:0]     ram_write_data,
  input  logic [DATA_BUS-1:0]     ram_read_data,
  input  logic                    ram_ready,
  output logic                    stall_req,
  output logic                    out_valid,
  output logic                    write_reg_en,
  output logic [REG_ADDR_BUS-1:0] write_reg_addr,
  output logic [DATA_BUS-1:0]     write_data,
  output logic                    addr_err_load,
  output logic                    addr_err_store,
  output logic [ADDR_BUS-1:0]     bad_vaddr,
  output logic                    state_dbg
);

  mem_state_e              state;
  logic [INST_OP_BUS-1:0]  op_q;
  logic [1:0]              off_q;
  logic [DATA_BUS-1:0]     rt_q;
  logic [REG_ADDR_BUS-1:0] wa_q;
  logic                    drop_q;   // flush seen during the access

  // The aligner sees the incoming instruction in IDLE (lane select, store
  // data, misalignment) and the captured one in ACCESS (load merge).
  logic [INST_OP_BUS-1:0]  al_op;
  logic [1:0]              al_off;
  logic [DATA_BUS-1:0]     al_rt;
  logic [BYTE_SEL_BUS-1:0] al_sel;
  logic [DATA_BUS-1:0]     al_wdata;
  logic [DATA_BUS-1:0]     al_load;
  logic                    al_misalign;
  logic                    accept_mem;

  assign al_op  = (state == MEM_IDLE) ? mem_op        : op_q;
  assign al_off = (state == MEM_IDLE) ? mem_addr[1:0] : off_q;
  assign al_rt  = (state == MEM_IDLE) ? rt_data       : rt_q;

  mem_align u_align (
    .op         (al_op),
    .offset     (al_off),
    .rt         (al_rt),
    .read_word  (ram_read_data),
    .ram_sel    (al_sel),
    .write_data (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  assign accept_mem = (state == MEM_IDLE) && in_valid && !flush &&
                      is_mem_op(mem_op) && !al_misalign;
  assign stall_req  = accept_mem || ((state == MEM_ACCESS) && !ram_ready);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= MEM_IDLE;
      op_q           <= '0;
      off_q          <= '0;
      rt_q           <= '0;
      wa_q           <= '0;
      drop_q         <= 1'b0;
      ram_en         <= 1'b0;
      ram_write_en   <= 1'b0;
      ram_sel        <= SEL_NONE;
      ram_addr       <= '0;
      ram_write_data <= '0;
      out_valid      <= 1'b0;
      write_reg_en   <= 1'b0;
      write_reg_addr <= '0;
      write_data     <= '0;
      addr_err_load  <= 1'b0;
      addr_err_store <= 1'b0;
      bad_vaddr      <= '0;
    end else begin
      out_valid      <= 1'b0;
      addr_err_load  <= 1'b0;
      addr_err_store <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (in_valid && !flush) begin
            if (!is_mem_op(mem_op)) begin
              out_valid      <= 1'b1;
              write_reg_en   <= in_wreg_en;
              write_reg_addr <= in_wreg_addr;
              write_data     <= in_wreg_data;
            end else if (al_misalign) begin
              out_valid      <= 1'b1;
              write_reg_en   <= 1'b0;
              write_reg_addr <= in_wreg_addr;
              addr_err_load  <= !is_store_op(mem_op);
              addr_err_store <= is_store_op(mem_op);
              bad_vaddr      <= mem_addr;
            end else begin
              op_q           <= mem_op;
              off_q          <= mem_addr[1:0];
              rt_q           <= rt_data;
              wa_q           <= in_wreg_addr;
              drop_q         <= 1'b0;
              ram_en         <= 1'b1;
              ram_write_en   <= is_store_op(mem_op);
              ram_sel        <= al_sel;
              ram_addr       <= {mem_addr[ADDR_BUS-1:2], 2'b00};
              ram_write_data <= al_wdata;
              state          <= MEM_ACCESS;
            end
          end
        end
        MEM_ACCESS: begin
          if (ram_ready) begin
            ram_en       <= 1'b0;
            ram_write_en <= 1'b0;
            state        <= MEM_IDLE;
            // A flushed access still completes on the bus; only the
            // writeback is suppressed.
            if (!(drop_q || flush)) begin
              out_valid      <= 1'b1;
              write_reg_addr <= wa_q;
              if (is_store_op(op_q)) begin
                write_reg_en <= 1'b0;
              end else begin
                write_reg_en <= 1'b1;
                write_data   <= al_load;
              end
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sl.sv
// tb_mem_sl: self-checking bench for mem_sl with a byte-level reference
// model, directed corner cases and randomized load/store traffic.
module tb_mem_sl;
  import mem_sl_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic [5:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] rt_data;
  logic        in_wreg_en;
  logic [4:0]  in_wreg_addr;
  logic [31:0] in_wreg_data;
  logic        ram_en;
  logic        ram_write_en;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;
  logic        stall_req;
  logic        out_valid;
  logic        write_reg_en;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_data;
  logic        addr_err_load;
  logic        addr_err_store;
  logic [31:0] bad_vaddr;
  logic        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_sl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .flush          (flush),
    .mem_op         (mem_op),
    .mem_addr       (mem_addr),
    .rt_data        (rt_data),
    .in_wreg_en     (in_wreg_en),
    .in_wreg_addr   (in_wreg_addr),
    .in_wreg_data   (in_wreg_data),
    .ram_en         (ram_en),
    .ram_write_en   (ram_write_en),
    .ram_sel        (ram_sel),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .ram_ready      (ram_ready),
    .stall_req      (stall_req),
    .out_valid      (out_valid),
    .write_reg_en   (write_reg_en),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .addr_err_load  (addr_err_load),
    .addr_err_store (addr_err_store),
    .bad_vaddr      (bad_vaddr),
    .state_dbg      (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: little-endian byte arithmetic on the architectural rules.
  task automatic model(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [31:0] word,
                       output bit mem, output bit st, output bit mis,
                       output logic [3:0] sel, output logic [31:0] wdat,
                       output logic [31:0] res);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] t;
    o = int'(addr[1:0]);
    t = word >> (8 * o);
    b = t[7:0];
    t = word >> (16 * (o / 2));
    h = t[15:0];
    mem = 1'b1; st = 1'b0; mis = 1'b0;
    sel = 4'b0000; wdat = 32'h0; res = 32'h0;
    case (op)
      OP_LB:  begin sel = 4'(1 << o); res = {{24{b[7]}}, b}; end
      OP_LBU: begin sel = 4'(1 << o); res = {24'h0, b}; end
      OP_LH:  begin sel = (o >= 2) ? 4'b1100 : 4'b0011; res = {{16{h[15]}}, h}; mis = (o % 2) != 0; end
      OP_LHU: begin sel = (o >= 2) ? 4'b1100 : 4'b0011; res = {16'h0, h}; mis = (o % 2) != 0; end
      OP_LW:  begin sel = 4'b1111; res = word; mis = (o != 0); end
      OP_LWL: begin
        sel = 4'b1111;
        res = (word << (8 * (3 - o))) | (rt & (32'hFFFF_FFFF >> (8 * (o + 1))));
      end
      OP_LWR: begin
        sel = 4'b1111;
        res = (word >> (8 * o)) | (rt & ~(32'hFFFF_FFFF >> (8 * o)));
      end
      OP_SB:  begin st = 1'b1; sel = 4'(1 << o); wdat = {4{rt[7:0]}}; end
      OP_SH:  begin st = 1'b1; sel = (o >= 2) ? 4'b1100 : 4'b0011; wdat = {2{rt[15:0]}}; mis = (o % 2) != 0; end
      OP_SW:  begin st = 1'b1; sel = 4'b1111; wdat = rt; mis = (o != 0); end
      OP_SWL: begin st = 1'b1; sel = 4'((1 << (o + 1)) - 1); wdat = rt >> (8 * (3 - o)); end
      OP_SWR: begin st = 1'b1; sel = 4'(4'b1111 << o); wdat = rt << (8 * o); end
      default: mem = 1'b0;
    endcase
  endtask

  // Driver: issue one instruction at a negedge and follow it to completion.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] wa, input logic [31:0] wd, input int waits,
                        input logic [31:0] word, input bit do_flush);
    bit mem, st, mis;
    logic [3:0]  sel;
    logic [31:0] wdat, res, exp_res;
    model(op, addr, rt, word, mem, st, mis, sel, wdat, res);
    mem_op = op; mem_addr = addr; rt_data = rt;
    in_wreg_en = 1'b1; in_wreg_addr = wa; in_wreg_data = wd;
    in_valid = 1'b1; flush = 1'b0;
    #1 check("stall_issue", stall_req, mem && !mis);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (!mem || mis) begin
      check("out_valid_1cyc", out_valid, 1);
      check("ram_en_none", ram_en, 0);
      check("state_idle", state_dbg, 0);
      if (!mem) begin
        check("wreg_en_alu", write_reg_en, 1);
        check("wreg_addr_alu", write_reg_addr, wa);
        check("wdata_alu", write_data, wd);
      end else begin
        check("wreg_en_mis", write_reg_en, 0);
        check("adel", addr_err_load, !st);
        check("ades", addr_err_store, st);
        check("bad_vaddr", bad_vaddr, addr);
      end
      @(negedge clk);
      check("out_valid_pulse", out_valid, 0);
      check("err_pulse", {addr_err_load, addr_err_store}, 0);
    end else begin
      exp_q.push_back(res);
      check("ram_en", ram_en, 1);
      check("ram_we", ram_write_en, st);
      check("ram_sel", ram_sel, sel);
      check("ram_addr", ram_addr, {addr[31:2], 2'b00});
      check("state_access", state_dbg, 1);
      if (st) check("ram_wdata", ram_write_data, wdat);
      for (int k = 0; k <= waits; k++) begin
        ram_ready = (k == waits);
        ram_read_data = word;
        flush = do_flush && (k == 0);
        #1;
        check("stall_access", stall_req, k != waits);
        check("ram_en_hold", ram_en, 1);
        check("ram_sel_hold", ram_sel, sel);
        check("out_valid_wait", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        ram_ready = 1'b0;
        flush = 1'b0;
        ram_read_data = $urandom;
      end
      exp_res = exp_q.pop_front();
      check("ram_en_release", ram_en, 0);
      check("state_back_idle", state_dbg, 0);
      check("out_valid_mem", out_valid, !do_flush);
      if (!do_flush) begin
        check("wreg_en_mem", write_reg_en, !st);
        if (!st) begin
          check("wreg_addr_load", write_reg_addr, wa);
          check("load_data", write_data, exp_res);
        end
      end
      @(negedge clk);
      check("out_valid_pulse_mem", out_valid, 0);
    end
  endtask

  logic [5:0] op_tab [13];

  initial begin
    op_tab = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
               OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, 6'h00};
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; mem_op = 6'h00; mem_addr = 32'h0;
    rt_data = 32'h0; in_wreg_en = 1'b0; in_wreg_addr = 5'd0; in_wreg_data = 32'h0;
    ram_read_data = 32'h0; ram_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_sel", ram_sel, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wdata", write_data, 0);
    check("rst_bad_vaddr", bad_vaddr, 0);
    check("rst_stall", stall_req, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b1;
    @(negedge clk);

    // ram_ready in IDLE has no effect
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    check("idle_ready_ign_state", state_dbg, 0);
    check("idle_ready_ign_ov", out_valid, 0);

    // Directed cases
    run_op(OP_SW,  32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0, 32'h0, 1'b0);
    run_op(OP_LB,  32'h103, 32'h0, 5'd2, 32'h0, 3, 32'h80112233, 1'b0);
    run_op(OP_LBU, 32'h103, 32'h0, 5'd3, 32'h0, 3, 32'h80112233, 1'b0);
    run_op(OP_LWL, 32'h101, 32'h11223344, 5'd4, 32'h0, 0, 32'hAABBCCDD, 1'b0);
    run_op(OP_LWR, 32'h102, 32'h11223344, 5'd5, 32'h0, 1, 32'hAABBCCDD, 1'b0);
    run_op(OP_SWR, 32'h203, 32'h11223344, 5'd6, 32'h0, 0, 32'h0, 1'b0);
    run_op(OP_SH,  32'h202, 32'h0000BEEF, 5'd7, 32'h0, 0, 32'h0, 1'b0);
    run_op(OP_LW,  32'h102, 32'h0, 5'd8, 32'h0, 0, 32'h0, 1'b0);
    run_op(OP_SH,  32'h201, 32'h0, 5'd9, 32'h0, 0, 32'h0, 1'b0);
    run_op(6'h00,  32'h0, 32'h0, 5'd10, 32'h12345678, 0, 32'h0, 1'b0);
    run_op(OP_LH,  32'h106, 32'h0, 5'd11, 32'h0, 2, 32'h8001F00F, 1'b0);
    run_op(OP_LW,  32'h108, 32'h0, 5'd12, 32'h0, 2, 32'hCAFEF00D, 1'b1);

    // Flush in IDLE drops the instruction
    mem_op = OP_LW; mem_addr = 32'h104; in_valid = 1'b1; flush = 1'b1;
    #1 check("flush_idle_stall", stall_req, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ram_en", ram_en, 0);
    check("flush_idle_ov", out_valid, 0);
    check("flush_idle_state", state_dbg, 0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      run_op(op_tab[$urandom_range(0, 12)], $urandom & 32'h0000_0FFF, $urandom,
             5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3), $urandom,
             ($urandom_range(0, 7) == 0));
    end

    // Reset asserted mid-access
    mem_op = OP_LW; mem_addr = 32'h300; rt_data = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; ram_ready = 1'b0;
    check("midrst_pre_ram_en", ram_en, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_ram_en", ram_en, 0);
    check("midrst_state", state_dbg, 0);
    check("midrst_ram_sel", ram_sel, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_wdata", write_data, 0);
    check("midrst_ov", out_valid, 0);
    check("midrst_stall", stall_req, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ov", out_valid, 0);
    check("post_rst_ram_en", ram_en, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
